// File: rtl/mux_using_mux_pkg.sv
// mux_using_mux_pkg: shared lane/select constants for the hierarchical 8:1 selector
package mux_using_mux_pkg;
    localparam int NUM_LANES = 8;
    localparam int SEL_W     = 3;

    // Lane number addressed by a select code; every code maps to a real lane
    function automatic int lane_index(input logic [SEL_W-1:0] s);
        return int'(s);
    endfunction
endpackage

// File: rtl/mux_using_mux_if.sv
// mux_using_mux_if: packed lanes, select and valid in; registered lane and valid out
interface mux_using_mux_if
    import mux_using_mux_pkg::*;
#(
    parameter int WIDTH = 1
);
    logic [NUM_LANES*WIDTH-1:0] a;
    logic [SEL_W-1:0]           s;
    logic                       in_valid;
    logic [WIDTH-1:0]           y;
    logic                       out_valid;

    modport master (output a, s, in_valid, input y, out_valid);
    modport slave  (input a, s, in_valid, output y, out_valid);
endinterface

// File: rtl/mux_using_mux_mux4to1.sv
// mux4to1: combinational 4:1 lane selector, lane 0 in the LSBs of d
module mux4to1 #(
    parameter int WIDTH = 1
) (
    input  logic [4*WIDTH-1:0] d,
    input  logic [1:0]         s,
    output logic [WIDTH-1:0]   y
);
    logic [WIDTH-1:0] l0, l1, l2, l3;

    assign l0 = d[0*WIDTH +: WIDTH];
    assign l1 = d[1*WIDTH +: WIDTH];
    assign l2 = d[2*WIDTH +: WIDTH];
    assign l3 = d[3*WIDTH +: WIDTH];

    always_comb y = s[1] ? (s[0] ? l3 : l2) : (s[0] ? l1 : l0);
endmodule

// File: rtl/mux_using_mux.sv
// mux_using_mux: 8:1 lane selector from two 4:1 nibble muxes and a 2:1 stage,
// with a single output register so y/out_valid follow a valid input by one cycle.
module mux_using_mux
    import mux_using_mux_pkg::*;
#(
    parameter int WIDTH = 1
) (
    input logic            clk,
    input logic            rst_n,
    mux_using_mux_if.slave bus
);
    logic [WIDTH-1:0] lo, hi, sel;

    mux4to1 #(.WIDTH(WIDTH)) u_lo (
        .d (bus.a[4*WIDTH-1:0]),
        .s (bus.s[1:0]),
        .y (lo)
    );

    mux4to1 #(.WIDTH(WIDTH)) u_hi (
        .d (bus.a[NUM_LANES*WIDTH-1:4*WIDTH]),
        .s (bus.s[1:0]),
        .y (hi)
    );

    always_comb sel = bus.s[SEL_W-1] ? hi : lo;

    // y keeps its last captured lane while idle; only out_valid tracks in_valid
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.y         <= '0;
            bus.out_valid <= 1'b0;
        end else begin
            bus.out_valid <= bus.in_valid;
            if (bus.in_valid) bus.y <= sel;
        end
    end
endmodule

// File: tb/tb_mux_using_mux.sv
// tb_mux_using_mux: directed and random checks of mux_using_mux at WIDTH=1 and WIDTH=4
module tb_mux_using_mux;
    import mux_using_mux_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;

    mux_using_mux_if #(.WIDTH(1)) if1 ();
    mux_using_mux_if #(.WIDTH(4)) if4 ();

    mux_using_mux #(.WIDTH(1)) d1 (.clk(clk), .rst_n(rst_n), .bus(if1));
    mux_using_mux #(.WIDTH(4)) d4 (.clk(clk), .rst_n(rst_n), .bus(if4));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int exp1 [8] = '{1, 0, 1, 1, 0, 1, 0, 1};
        logic [0:0] m1;
        logic [3:0] m4;
        if1.a = '0; if1.s = '0; if1.in_valid = 1'b0;
        if4.a = '0; if4.s = '0; if4.in_valid = 1'b0;
        #3;
        chk("rst_y1", if1.y, 0);
        chk("rst_ov1", if1.out_valid, 0);
        chk("rst_y4", if4.y, 0);
        step();
        rst_n = 1'b1;
        step();
        chk("idle_ov", if1.out_valid, 0);

        if1.a = 8'b10101101;
        if1.in_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            if1.s = 3'(i);
            step();
            chk($sformatf("sweep_y%0d", i), if1.y, exp1[i]);
            chk($sformatf("sweep_ov%0d", i), if1.out_valid, 1);
        end

        if1.in_valid = 1'b0;
        if1.a = 8'h00;
        if1.s = 3'd1;
        step();
        chk("hold_y", if1.y, 1);
        chk("hold_ov", if1.out_valid, 0);

        if1.a = 8'hFF;
        if1.s = 3'd7;
        if1.in_valid = 1'b1;
        step();
        chk("pre_rst_ov", if1.out_valid, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_y", if1.y, 0);
        chk("async_ov", if1.out_valid, 0);
        step();
        chk("rst_hold_ov", if1.out_valid, 0);
        rst_n = 1'b1;
        step();
        chk("post_rst_y", if1.y, 1);
        chk("post_rst_ov", if1.out_valid, 1);

        if1.a = 8'b00010000;
        if1.s = 3'd4;
        step();
        chk("nib_s4", if1.y, 1);
        if1.s = 3'd3;
        step();
        chk("nib_s3", if1.y, 0);
        if1.s = 3'd0;
        step();
        chk("nib_s0", if1.y, 0);
        if1.in_valid = 1'b0;

        if4.a = 32'h76543210;
        if4.in_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            if4.s = 3'(i);
            step();
            chk($sformatf("w4_s%0d", i), if4.y, i);
        end
        if4.in_valid = 1'b0;
        step();
        chk("w4_idle_ov", if4.out_valid, 0);

        m1 = 1'b0;
        m4 = 4'h7;
        for (int n = 0; n < 1000; n++) begin
            if1.a = 8'($urandom);
            if1.s = 3'($urandom_range(0, 7));
            if1.in_valid = 1'($urandom);
            if4.a = $urandom;
            if4.s = 3'($urandom_range(0, 7));
            if4.in_valid = 1'($urandom);
            if (if1.in_valid) m1 = if1.a[lane_index(if1.s) +: 1];
            if (if4.in_valid) m4 = if4.a[lane_index(if4.s)*4 +: 4];
            step();
            chk("rnd_y1", if1.y, m1);
            chk("rnd_ov1", if1.out_valid, if1.in_valid);
            chk("rnd_y4", if4.y, m4);
            chk("rnd_ov4", if4.out_valid, if4.in_valid);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
